ps2_scan_decoder: RTL



---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_frame_rx.sv | 134 +++++++++++++
 rtl/ps2_scan_decoder.sv | 83 ++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, frame-FSM state type and frame check helper for the
// PS/2 keyboard front end.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;
  localparam int         FRAME_BITS     = 10;

  typedef enum logic {
    IDLE,
    RECV
  } frame_state_t;

  // A frame after the start bit is {stop, parity, data[7:0]}.
  // It is good when parity makes the nine bits odd and the stop bit is high.
  function automatic logic frame_ok(input logic [9:0] frame);
    return (^frame[8:0]) && frame[9];
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame
// FSM with parity/stop/timeout checks, and raw byte output.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     LAST_BIT = 4'(FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   sync_clk;
  logic                   sync_clk_d;
  logic                   sync_data;
  logic                   fall;

  frame_state_t  state, state_next;
  logic [3:0]    bit_cnt, bit_cnt_next;
  logic [TW-1:0] tmo_cnt, tmo_next;
  logic [8:0]    shreg, shreg_next;
  logic [9:0]    frame;
  logic          byte_valid_next;
  logic [7:0]    byte_data_next;
  logic          frame_err_next;

  // Synchronise both pins into clk and keep one cycle of history on the clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: synchroniser flops reset to 1, the bus idle level, so leaving reset never fakes a falling edge.
      clk_sync   <= '1;
      data_sync  <= '1;
      sync_clk_d <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true shift chain.
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      sync_clk_d <= sync_clk;
    end
  end

  assign sync_clk  = clk_sync[SYNC_STAGES-1];
  assign sync_data = data_sync[SYNC_STAGES-1];
  assign fall      = sync_clk_d && !sync_clk;

  // Complete frame as it stands on the stop-bit edge.
  assign frame = {sync_data, shreg};

  // Frame FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      tmo_cnt    <= tmo_next;
      shreg      <= shreg_next;
      byte_valid <= byte_valid_next;
      byte_data  <= byte_data_next;
      frame_err  <= frame_err_next;
    end
  end

  // Next-state logic: start detect, bit capture, frame validation, timeout abort.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
    state_next      = state;
    bit_cnt_next    = bit_cnt;
    tmo_next        = tmo_cnt;
    shreg_next      = shreg;
    byte_valid_next = 1'b0;
    byte_data_next  = byte_data;
    frame_err_next  = 1'b0;

    case (state)
      IDLE: begin
        if (fall && !sync_data) begin
          state_next   = RECV;
          bit_cnt_next = '0;
          tmo_next     = '0;
          shreg_next   = '0;
        end
      end

      RECV: begin
        if (fall) begin
          // An edge always restarts the inter-edge timer, even on the timeout cycle.
          tmo_next = '0;
          if (bit_cnt == LAST_BIT) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            if (frame_ok(frame)) begin
              byte_valid_next = 1'b1;
              byte_data_next  = frame[7:0];
            end else begin
              frame_err_next = 1'b1;
            end
          end else begin
            shreg_next   = {sync_data, shreg[8:1]};
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
          bit_cnt_next   = '0;
          tmo_next       = '0;
          shreg_next     = '0;
        end else begin
          tmo_next = tmo_cnt + TW'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard front end: frame receiver plus E0/F0/E1 prefix decoder that
// emits one key event per physical key action.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err
);

  logic       ext_pend;
  logic       brk_pend;
  logic [2:0] skip_cnt;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // Prefix decoder: fold E0/F0 into flags, swallow the pause tail, emit events.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      skip_cnt    <= '0;
    end else begin
      key_valid <= 1'b0;
      if (frame_err) begin
        // A corrupted byte poisons any multi-byte sequence in progress.
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
        skip_cnt <= '0;
      end else if (byte_valid) begin
        if (skip_cnt != '0) begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) begin
            key_valid   <= 1'b1;
            key_code    <= PS2_PAUSE;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
          end
        end else if (byte_data == PS2_PAUSE) begin
          skip_cnt <= PS2_PAUSE_TAIL;
        end else if (byte_data == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (byte_data == PS2_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          key_valid   <= 1'b1;
          key_code    <= byte_data;
          key_ext     <= ext_pend;
          key_release <= brk_pend;
          ext_pend    <= 1'b0;
          brk_pend    <= 1'b0;
        end
      end
    end
  end

endmodule
